// File: rtl/btree_prio_select.sv
// Pipelined binary-tree priority selector.
// Reduces a hit-flag vector to an any-hit flag plus the winning index. Winner polarity
// (highest or lowest set index) is chosen per vector and travels with it. A register
// stage is inserted every LEVELS_PER_STAGE tree levels, and always after the last level.
module btree_prio_select #(
  parameter int unsigned INPUT_COUNT      = 64,
  parameter int unsigned INDEX_WIDTH      = 6,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [INPUT_COUNT-1:0] flags_in,
  input  logic                   lowest_first,
  output logic                   out_valid,
  output logic                   flag_out,
  output logic [INDEX_WIDTH-1:0] data_out
);

  localparam int unsigned Levels = $clog2(INPUT_COUNT);
  localparam int unsigned Padded = 1 << Levels;

  // Level l carries the results of l tree levels: Padded >> l nodes, each with a flag and
  // an index whose low l bits are meaningful. A node's index is zero whenever its flag is.
  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    localparam int unsigned Nodes = Padded >> l;
    localparam bit IsReg = (l > 0) && (((l % LEVELS_PER_STAGE) == 0) || (l == Levels));

    logic [Nodes-1:0]       f_s;
    logic [INDEX_WIDTH-1:0] i_s [Nodes];
    logic                   v_s;

    // Mode is only consumed by the next level, so the final level has none.
    if (l < Levels) begin : g_m
      logic m_s;
      if (l == 0) begin : g_src
        assign m_s = lowest_first;
      end else if (IsReg) begin : g_reg
        logic m_q;
        // Mode register advances with the stage data.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            m_q <= 1'b0;
          end else if (ce) begin
            m_q <= g_lvl[l-1].g_m.m_s;
          end
        end
        assign m_s = m_q;
      end else begin : g_pass
        assign m_s = g_lvl[l-1].g_m.m_s;
      end
    end

    if (l == 0) begin : g_leaf
      // Padding leaves above INPUT_COUNT-1 are tied to zero so they can never win.
      for (genvar n = 0; n < Padded; n++) begin : g_pad
        if (n < INPUT_COUNT) begin : g_real
          assign f_s[n] = flags_in[n];
        end else begin : g_zero
          assign f_s[n] = 1'b0;
        end
        assign i_s[n] = '0;
      end
      assign v_s = in_valid;
    end else begin : g_tree
      logic [Nodes-1:0]       f_c;
      logic [INDEX_WIDTH-1:0] i_c [Nodes];

      for (genvar n = 0; n < Nodes; n++) begin : g_node
        logic f_hi;
        logic f_lo;
        logic sel;
        assign f_hi   = g_lvl[l-1].f_s[2*n+1];
        assign f_lo   = g_lvl[l-1].f_s[2*n];
        assign f_c[n] = f_hi | f_lo;
        // sel stays 0 when neither child hits, keeping the empty-node index at zero.
        assign sel    = g_lvl[l-1].g_m.m_s ? (f_hi & ~f_lo) : f_hi;
        assign i_c[n] = sel ? (g_lvl[l-1].i_s[2*n+1] | (INDEX_WIDTH'(1) << (l-1)))
                            : g_lvl[l-1].i_s[2*n];
      end

      if (IsReg) begin : g_reg
        logic [Nodes-1:0]       f_q;
        logic [INDEX_WIDTH-1:0] i_q [Nodes];
        logic                   v_q;
        // Stage register: holds on ce=0, cleared asynchronously on reset.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            v_q <= 1'b0;
            f_q <= '0;
            for (int unsigned n = 0; n < Nodes; n++) begin
              i_q[n] <= '0;
            end
          end else if (ce) begin
            v_q <= g_lvl[l-1].v_s;
            f_q <= f_c;
            for (int unsigned n = 0; n < Nodes; n++) begin
              i_q[n] <= i_c[n];
            end
          end
        end
        assign f_s = f_q;
        assign v_s = v_q;
        for (genvar n = 0; n < Nodes; n++) begin : g_out
          assign i_s[n] = i_q[n];
        end
      end else begin : g_comb
        assign f_s = f_c;
        assign v_s = g_lvl[l-1].v_s;
        for (genvar n = 0; n < Nodes; n++) begin : g_out
          assign i_s[n] = i_c[n];
        end
      end
    end
  end

  // Bubbles may leave stale data in the last stage, so outputs are gated by valid.
  assign out_valid = g_lvl[Levels].v_s;
  assign flag_out  = out_valid & g_lvl[Levels].f_s[0];
  assign data_out  = out_valid ? g_lvl[Levels].i_s[0] : '0;

endmodule

// File: tb/tb_btree_prio_select.sv
// Directed bench for btree_prio_select: a 64-input default instance and a 40-input,
// one-level-per-stage instance sharing clock, reset and ce.
module tb_btree_prio_select;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;

  logic        a_valid;
  logic [63:0] a_flags;
  logic        a_lf;
  logic        a_ov;
  logic        a_fo;
  logic [5:0]  a_do;

  logic        b_valid;
  logic [39:0] b_flags;
  logic        b_lf;
  logic        b_ov;
  logic        b_fo;
  logic [5:0]  b_do;

  int checks = 0;
  int errors = 0;

  btree_prio_select #(
    .INPUT_COUNT(64),
    .INDEX_WIDTH(6),
    .LEVELS_PER_STAGE(2)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (a_valid),
    .flags_in    (a_flags),
    .lowest_first(a_lf),
    .out_valid   (a_ov),
    .flag_out    (a_fo),
    .data_out    (a_do)
  );

  btree_prio_select #(
    .INPUT_COUNT(40),
    .INDEX_WIDTH(6),
    .LEVELS_PER_STAGE(1)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (b_valid),
    .flags_in    (b_flags),
    .lowest_first(b_lf),
    .out_valid   (b_ov),
    .flag_out    (b_fo),
    .data_out    (b_do)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic f, input logic [5:0] d);
    chk({tag, "_a_valid"}, {31'd0, a_ov}, {31'd0, v});
    chk({tag, "_a_flag"}, {31'd0, a_fo}, {31'd0, f});
    chk({tag, "_a_data"}, {26'd0, a_do}, {26'd0, d});
  endtask

  task automatic chk_b(input string tag, input logic v, input logic f, input logic [5:0] d);
    chk({tag, "_b_valid"}, {31'd0, b_ov}, {31'd0, v});
    chk({tag, "_b_flag"}, {31'd0, b_fo}, {31'd0, f});
    chk({tag, "_b_data"}, {26'd0, b_do}, {26'd0, d});
  endtask

  task automatic send_a(input logic [63:0] f, input logic lf);
    a_valid = 1'b1;
    a_flags = f;
    a_lf    = lf;
    cyc();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [39:0] f, input logic lf);
    b_valid = 1'b1;
    b_flags = f;
    b_lf    = lf;
    cyc();
    b_valid = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    ce      = 1'b1;
    a_valid = 1'b1;
    a_flags = '1;
    a_lf    = 1'b0;
    b_valid = 1'b0;
    b_flags = '0;
    b_lf    = 1'b0;

    // Asynchronous reset clears outputs before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk_a("reset_async", 1'b0, 1'b0, 6'd0);
    chk_b("reset_async", 1'b0, 1'b0, 6'd0);

    // ce=1 with reset held: the vector presented is not accepted.
    cyc();
    chk_a("reset_ce", 1'b0, 1'b0, 6'd0);
    reset   = 1'b0;
    a_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk_a("post_reset_idle", 1'b0, 1'b0, 6'd0);

    // All-zero flags: valid result with no hit after 3 cycles.
    send_a(64'd0, 1'b0);
    cyc();
    chk_a("zero_lat2", 1'b0, 1'b0, 6'd0);
    cyc();
    chk_a("zero_flags", 1'b1, 1'b0, 6'd0);

    // Bits 5 and 40 with both polarities, back to back.
    send_a((64'd1 << 5) | (64'd1 << 40), 1'b0);
    send_a((64'd1 << 5) | (64'd1 << 40), 1'b1);
    cyc();
    chk_a("two_hi", 1'b1, 1'b1, 6'd40);
    cyc();
    chk_a("two_lo", 1'b1, 1'b1, 6'd5);
    cyc();
    chk_a("bubble", 1'b0, 1'b0, 6'd0);

    // One-hot stream, alternating polarity, one result per cycle.
    for (int k = 0; k < 64; k++) begin
      send_a(64'd1 << k, k[0]);
      if (k >= 2) chk_a("stream", 1'b1, 1'b1, 6'(k - 2));
    end
    cyc();
    chk_a("stream_62", 1'b1, 1'b1, 6'd62);
    cyc();
    chk_a("stream_63", 1'b1, 1'b1, 6'd63);
    cyc();
    chk_a("stream_end", 1'b0, 1'b0, 6'd0);

    // Stall mid-stream for two cycles; inputs offered during the stall are ignored.
    send_a(64'd1 << 10, 1'b0);
    send_a(64'd1 << 20, 1'b1);
    send_a(64'd1 << 30, 1'b0);
    chk_a("pre_stall", 1'b1, 1'b1, 6'd10);
    ce      = 1'b0;
    a_valid = 1'b1;
    a_flags = '1;
    a_lf    = 1'b1;
    cyc();
    chk_a("stall_1", 1'b1, 1'b1, 6'd10);
    cyc();
    chk_a("stall_2", 1'b1, 1'b1, 6'd10);
    ce      = 1'b1;
    a_valid = 1'b0;
    cyc();
    chk_a("resume_1", 1'b1, 1'b1, 6'd20);
    cyc();
    chk_a("resume_2", 1'b1, 1'b1, 6'd30);
    cyc();
    chk_a("resume_end", 1'b0, 1'b0, 6'd0);

    // Reset mid-stream with vectors in flight.
    send_a(64'd1 << 1, 1'b0);
    send_a(64'd1 << 2, 1'b0);
    send_a(64'd1 << 3, 1'b0);
    chk_a("pre_reset", 1'b1, 1'b1, 6'd1);
    #2 reset = 1'b1;
    #1;
    chk_a("mid_reset", 1'b0, 1'b0, 6'd0);
    a_valid = 1'b1;
    a_flags = 64'd1 << 9;
    cyc();
    chk_a("reset_hold", 1'b0, 1'b0, 6'd0);
    reset   = 1'b0;
    a_valid = 1'b0;
    send_a(64'd1 << 7, 1'b0);
    chk_a("flush_1", 1'b0, 1'b0, 6'd0);
    cyc();
    chk_a("flush_2", 1'b0, 1'b0, 6'd0);
    cyc();
    chk_a("first_new", 1'b1, 1'b1, 6'd7);

    // All ones with both polarities.
    send_a('1, 1'b0);
    send_a('1, 1'b1);
    cyc();
    chk_a("ones_hi", 1'b1, 1'b1, 6'd63);
    cyc();
    chk_a("ones_lo", 1'b1, 1'b1, 6'd0);

    // 40-input, 6-stage instance: latency and padding.
    send_b(40'd1 << 39, 1'b0);
    send_b('1, 1'b1);
    send_b('1, 1'b0);
    cyc();
    cyc();
    chk_b("b_lat5", 1'b0, 1'b0, 6'd0);
    cyc();
    chk_b("b_bit39", 1'b1, 1'b1, 6'd39);
    cyc();
    chk_b("b_ones_lo", 1'b1, 1'b1, 6'd0);
    cyc();
    chk_b("b_ones_hi", 1'b1, 1'b1, 6'd39);
    cyc();
    chk_b("b_end", 1'b0, 1'b0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
